// File: rtl/tv80_clk_wait_ctrl_if.sv
// Core-facing bundle for the tv80 clock-enable / wait-state controller.
// master = controller side, slave = board/core side.
interface tv80_clk_wait_ctrl_if #(
  parameter int STAT_W = 16
);
  logic              turbo;
  logic              ext_wait_n;
  logic              m1_n;
  logic              iorq;
  logic [6:0]        ts;
  logic              stat_clr;
  logic              cen;
  logic              wait_n;
  logic [1:0]        cycle_type;
  logic              ws_active;
  logic [STAT_W-1:0] wait_total;

  modport master (
    input  turbo, ext_wait_n, m1_n, iorq, ts, stat_clr,
    output cen, wait_n, cycle_type, ws_active, wait_total
  );

  modport slave (
    output turbo, ext_wait_n, m1_n, iorq, ts, stat_clr,
    input  cen, wait_n, cycle_type, ws_active, wait_total
  );
endinterface

// File: rtl/tv80_clk_wait_ctrl.sv
// Clock-enable divider plus per-cycle-type wait-state inserter for tv80_core,
// with a saturating count of wait ticks seen by the core.
module tv80_clk_wait_ctrl #(
  parameter int CEN_DIV = 4,
  parameter int WS_W    = 4,
  parameter int M1_WS   = 1,
  parameter int MEM_WS  = 0,
  parameter int IO_WS   = 1,
  parameter int INTA_WS = 2,
  parameter int STAT_W  = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  tv80_clk_wait_ctrl_if.master bus
);
  localparam int DW     = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;
  localparam int WS_MAX = (1 << WS_W) - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  generate
    if (CEN_DIV < 1 || M1_WS > WS_MAX || MEM_WS > WS_MAX ||
        IO_WS > WS_MAX || INTA_WS > WS_MAX) begin : g_param_err
      $error("tv80_clk_wait_ctrl: CEN_DIV < 1 or a *_WS value exceeds 2**WS_W-1");
    end
  endgenerate

  // ---------------- divider ----------------
  logic [DW-1:0] div_cnt;
  logic          turbo_q;
  logic          cen_q;
  logic          div_last;

  assign div_last = (div_cnt == DW'(CEN_DIV - 1));

  // Turbo is only re-sampled when a pulse is issued, so leaving turbo
  // always starts a clean, full CEN_DIV period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      cen_q   <= 1'b0;
      turbo_q <= 1'b0;
    end else if (turbo_q || div_last) begin
      div_cnt <= '0;
      cen_q   <= 1'b1;
      turbo_q <= bus.turbo;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      cen_q   <= 1'b0;
    end
  end

  assign bus.cen = cen_q;

  // ---------------- wait FSM ----------------
  logic [1:0]      state;
  logic [WS_W-1:0] ws_cnt;
  logic [WS_W-1:0] sel_ws;
  logic [1:0]      type_now;
  logic [1:0]      type_q;
  logic            t2;
  logic            ws_req;
  logic            wait_int;
  logic            act;
  logic            unused_ts;

  assign t2        = bus.ts[1];
  assign unused_ts = ^{bus.ts[6:2], bus.ts[0]};

  always_comb begin
    type_now = {bus.iorq, bus.m1_n ^ bus.iorq};
    sel_ws   = '0;
    case (type_now)
      2'b00:   sel_ws = WS_W'(M1_WS);
      2'b01:   sel_ws = WS_W'(MEM_WS);
      2'b10:   sel_ws = WS_W'(IO_WS);
      default: sel_ws = WS_W'(INTA_WS);
    endcase
  end

  assign ws_req = t2 && (sel_ws != '0);

  always_comb begin
    wait_int = 1'b1;
    act      = 1'b0;
    case (state)
      S_IDLE:  begin wait_int = ~ws_req; act = ws_req; end
      S_COUNT: begin wait_int = 1'b0;    act = 1'b1;   end
      default: ;
    endcase
  end

  // Reset releases the core immediately, even mid-count.
  assign bus.wait_n     = bus.ext_wait_n & (wait_int | ~reset_n);
  assign bus.ws_active  = act & reset_n;
  assign bus.cycle_type = type_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      ws_cnt <= '0;
      type_q <= 2'b00;
    end else if (cen_q) begin
      case (state)
        S_IDLE: if (t2) begin
          type_q <= type_now;
          ws_cnt <= (sel_ws == '0) ? '0 : sel_ws - 1'b1;
          state  <= (sel_ws > WS_W'(1)) ? S_COUNT : S_DONE;
        end
        S_COUNT: begin
          ws_cnt <= ws_cnt - 1'b1;
          if (ws_cnt == WS_W'(1)) state <= S_DONE;
        end
        S_DONE: if (!t2) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- statistics ----------------
  logic [STAT_W-1:0] total_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  total_q <= '0;
    else if (bus.stat_clr)                         total_q <= '0;
    else if (cen_q && !bus.wait_n && !(&total_q))  total_q <= total_q + 1'b1;
  end

  assign bus.wait_total = total_q;

endmodule

// File: tb/tb_tv80_clk_wait_ctrl.sv
// Scoreboard bench: stimulus pushes per-clock expectations, a negedge monitor
// pops and compares them against the controller outputs.
module tb_tv80_clk_wait_ctrl;
  localparam logic [6:0] T1 = 7'b0000001;
  localparam logic [6:0] T2 = 7'b0000010;
  localparam logic [6:0] T3 = 7'b0000100;

  logic clk = 1'b0;
  logic reset_n;

  tv80_clk_wait_ctrl_if #(.STAT_W(4)) bus ();

  tv80_clk_wait_ctrl #(
    .CEN_DIV(4), .WS_W(4), .M1_WS(1), .MEM_WS(0), .IO_WS(1), .INTA_WS(2), .STAT_W(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cen;
    logic       wn;
    logic       act;
    logic [1:0] ty;
    int         tot;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    etot   = 0;
  logic [1:0] ety = 2'b00;

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
  endtask

  task automatic push(input string nm, input logic c, input logic w, input logic a,
                      input logic [1:0] t, input int tot);
    exp_t e;
    e.cen = c; e.wn = w; e.act = a; e.ty = t; e.tot = tot;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  // monitor
  exp_t  me;
  string mn;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      mn = nq.pop_front();
      cmp({mn, ".cen"},        int'(bus.cen),        int'(me.cen));
      cmp({mn, ".wait_n"},     int'(bus.wait_n),     int'(me.wn));
      cmp({mn, ".ws_active"},  int'(bus.ws_active),  int'(me.act));
      cmp({mn, ".cycle_type"}, int'(bus.cycle_type), int'(me.ty));
      cmp({mn, ".wait_total"}, int'(bus.wait_total), me.tot);
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle with cen every clk: T2 held while stalled, then T3, then T1.
  // Stall = max(internal, external); clr_at selects a tick with stat_clr high.
  task automatic cyc(input string nm, input logic m1v, input logic iov,
                     input logic [1:0] ty, input int ws, input int ext, input int clr_at);
    int n;
    n = (ws > ext) ? ws : ext;
    for (int i = 0; i <= n + 2; i++) begin
      adv();
      bus.m1_n       = m1v;
      bus.iorq       = iov;
      bus.ts         = (i <= n) ? T2 : ((i == n + 1) ? T3 : T1);
      bus.ext_wait_n = (i < ext) ? 1'b0 : 1'b1;
      bus.stat_clr   = (i == clr_at);
      push($sformatf("%s[%0d]", nm, i), 1'b1, (i < n) ? 1'b0 : 1'b1,
           (i < ws) ? 1'b1 : 1'b0, (i == 0) ? ety : ty, etot);
      if (i == clr_at)              etot = 0;
      else if (i < n && etot != 15) etot++;
    end
    ety = ty;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.turbo      = 1'b0;
    bus.ext_wait_n = 1'b1;
    bus.m1_n       = 1'b1;
    bus.iorq       = 1'b0;
    bus.ts         = T1;
    bus.stat_clr   = 1'b0;
    push("reset", 1'b0, 1'b1, 1'b0, 2'b00, 0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // divider: pulses at 4, 8; turbo seen at 12..16; restart gives 20, 24
    for (int k = 1; k <= 24; k++) begin
      adv();
      if (k == 8)  bus.turbo = 1'b1;
      if (k == 15) bus.turbo = 1'b0;
      if (k == 24) bus.turbo = 1'b1;
      push($sformatf("div%0d", k),
           (k == 4 || k == 8 || k == 20 || k == 24 || (k >= 12 && k <= 16)),
           1'b1, 1'b0, 2'b00, 0);
    end
    repeat (4) adv();

    cyc("m1",       1'b0, 1'b0, 2'b00, 1, 0, -1);
    cyc("inta",     1'b0, 1'b1, 2'b11, 2, 0, -1);
    cyc("mem",      1'b1, 1'b0, 2'b01, 0, 0, -1);
    cyc("io_ext",   1'b1, 1'b1, 2'b10, 1, 5, -1);
    cyc("inta_ext", 1'b0, 1'b1, 2'b11, 2, 1, -1);

    // reset during the second INTA wait tick
    adv();
    bus.m1_n = 1'b0; bus.iorq = 1'b1; bus.ts = T2; bus.ext_wait_n = 1'b1;
    push("rstw0", 1'b1, 1'b0, 1'b1, ety, etot);
    etot++;
    adv();
    reset_n = 1'b0;
    push("rstw1", 1'b0, 1'b1, 1'b0, 2'b00, 0);
    etot = 0; ety = 2'b00;
    adv();
    reset_n = 1'b1; bus.ts = T1; bus.m1_n = 1'b1; bus.iorq = 1'b0;
    push("rstw2", 1'b0, 1'b1, 1'b0, 2'b00, 0);
    for (int k = 1; k <= 4; k++) begin
      adv();
      push($sformatf("rdiv%0d", k), (k == 4), 1'b1, 1'b0, 2'b00, 0);
    end

    cyc("inta_rst", 1'b0, 1'b1, 2'b11, 2, 0, -1);
    cyc("sat1",     1'b1, 1'b1, 2'b10, 1, 15, -1);
    cyc("sat2",     1'b1, 1'b1, 2'b10, 1, 3, -1);
    cyc("clr",      1'b0, 1'b1, 2'b11, 2, 0, 0);

    adv();
    bus.stat_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    cmp("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
